ocimem_access_arbiter: RTL and testbench

Arbitrates the on-chip debug memory (ocimem, single-port synchronous RAM, 1-cycle read latency) between two requesters. The first is the JTAG debug path: it sees the sysclk-domain take_action_ocimem_a/b strobes plus jdo, and returns data through MonDReg. The second is the CPU's Avalon-MM debug slave. The block sits in the sysclk domain beside the debug-module sysclk logic and drives the RAM instance directly.

---
 rtl/ocimem_pkg.sv | 36 +++
 rtl/ocimem_jtag_cmd.sv | 86 ++++++++
 rtl/ocimem_access_arbiter.sv | 125 ++++++++++++
 tb/tb_ocimem_access_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocimem_pkg.sv
// ============================================================================
//  Module   : ocimem_pkg
//  Purpose  : Shared types and jdo field positions for the ocimem arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ocimem_pkg;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_AVS  = 2'd1,
      ST_RD_JTAG = 2'd2
   } state_e;

   // Identity of the requester that most recently owned the RAM
   typedef enum logic {
      GNT_JTAG = 1'b0,
      GNT_AVS  = 1'b1
   } grant_e;

   // Kind of JTAG operation held in the pending slot
   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } jop_e;

   // Field positions inside the 38-bit JTAG shift word
   localparam int JDO_ADDR_LSB  = 17;
   localparam int JDO_RDEN_BIT  = 34;
   localparam int JDO_WDATA_LSB = 3;

endpackage

`default_nettype wire

// File: rtl/ocimem_jtag_cmd.sv
// ============================================================================
//  Module   : ocimem_jtag_cmd
//  Purpose  : Decodes the JTAG ocimem strobes into a single pending RAM op,
//             keeps the auto-incrementing JTAG address and the sticky error.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ocimem_jtag_cmd
   import ocimem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo_i,
   input  logic              take_a_i,
   input  logic              take_b_i,
   input  logic              debugack_i,
   input  logic              done_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              pend_o,
   output jop_e              op_o,
   output logic [31:0]       wdata_o,
   output logic              error_o
);

   logic [ADDR_W-1:0] addr_q;
   logic              pend_q;
   jop_e              op_q;
   logic [31:0]       wdata_q;
   logic              error_q;

   // Bits of the shift word that carry nothing for the memory path
   logic unused_jdo_bits;
   assign unused_jdo_bits = ^{jdo_i[37:35], jdo_i[2:0]};

   // Pending-slot bookkeeping; a later assignment to error_q overrides an
   // earlier one so a dropped ocimem_b beside an accepted ocimem_a still flags
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         pend_q  <= 1'b0;
         op_q    <= OP_RD;
         wdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         if (done_i) begin
            pend_q <= 1'b0;
            addr_q <= addr_q + 1'b1;
         end
         if (take_a_i) begin
            if (pend_q) begin
               error_q <= 1'b1;
            end else begin
               addr_q  <= jdo_i[JDO_ADDR_LSB +: ADDR_W];
               error_q <= 1'b0;
               if (jdo_i[JDO_RDEN_BIT]) begin
                  pend_q <= 1'b1;
                  op_q   <= OP_RD;
               end
            end
            if (take_b_i) begin
               error_q <= 1'b1;
            end
         end else if (take_b_i) begin
            if (pend_q || !debugack_i) begin
               error_q <= 1'b1;
            end else begin
               pend_q  <= 1'b1;
               op_q    <= OP_WR;
               wdata_q <= jdo_i[JDO_WDATA_LSB +: 32];
            end
         end
      end
   end

   assign addr_o  = addr_q;
   assign pend_o  = pend_q;
   assign op_o    = op_q;
   assign wdata_o = wdata_q;
   assign error_o = error_q;

endmodule

`default_nettype wire

// File: rtl/ocimem_access_arbiter.sv
// ============================================================================
//  Module   : ocimem_access_arbiter
//  Purpose  : Round-robin arbitration of the single-port ocimem between the
//             JTAG debug path and the CPU Avalon-MM debug slave.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ocimem_access_arbiter
   import ocimem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              debugack,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [3:0]        ram_byteen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   state_e            state_q;
   grant_e            last_grant_q;
   logic [31:0]       mondreg_q;
   logic [31:0]       rdhold_q;

   logic [ADDR_W-1:0] jtag_addr;
   logic              jtag_pend;
   jop_e              jtag_op;
   logic [31:0]       jtag_wdata;

   logic              w_avs_req;
   logic              w_idle;
   logic              w_gnt_avs;
   logic              w_gnt_jtag;
   logic              w_jtag_done;

   ocimem_jtag_cmd #(
      .ADDR_W (ADDR_W)
   ) u_cmd (
      .clk        (clk),
      .reset      (reset),
      .jdo_i      (jdo),
      .take_a_i   (take_action_ocimem_a),
      .take_b_i   (take_action_ocimem_b),
      .debugack_i (debugack),
      .done_i     (w_jtag_done),
      .addr_o     (jtag_addr),
      .pend_o     (jtag_pend),
      .op_o       (jtag_op),
      .wdata_o    (jtag_wdata),
      .error_o    (monitor_error)
   );

   // Grant decision and RAM steering; the winner owns ram_* in the grant cycle
   always_comb begin
      w_avs_req  = avs_read | avs_write;
      w_idle     = (state_q == ST_IDLE) & ~reset;
      w_gnt_avs  = w_idle & w_avs_req & (~jtag_pend | (last_grant_q == GNT_JTAG));
      w_gnt_jtag = w_idle & jtag_pend & (~w_avs_req | (last_grant_q == GNT_AVS));

      ram_addr   = w_gnt_jtag ? jtag_addr  : avs_address;
      ram_wdata  = w_gnt_jtag ? jtag_wdata : avs_writedata;
      ram_byteen = w_gnt_jtag ? 4'hF       : avs_byteenable;
      ram_wren   = (w_gnt_avs & avs_write) | (w_gnt_jtag & (jtag_op == OP_WR));

      avs_waitrequest = ~((w_gnt_avs & avs_write) |
                          ((state_q == ST_RD_AVS) & ~reset));
      avs_readdata    = (state_q == ST_RD_AVS) ? ram_rdata : rdhold_q;

      w_jtag_done = (w_gnt_jtag & (jtag_op == OP_WR)) | (state_q == ST_RD_JTAG);
   end

   // Sequencer: a read grant spends one cycle collecting RAM data, writes stay in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GNT_JTAG;
         mondreg_q    <= '0;
         rdhold_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_gnt_avs) begin
                  last_grant_q <= GNT_AVS;
                  if (!avs_write) state_q <= ST_RD_AVS;
               end else if (w_gnt_jtag) begin
                  last_grant_q <= GNT_JTAG;
                  if (jtag_op == OP_RD) state_q <= ST_RD_JTAG;
               end
            end
            ST_RD_AVS: begin
               rdhold_q <= ram_rdata;
               state_q  <= ST_IDLE;
            end
            ST_RD_JTAG: begin
               mondreg_q <= ram_rdata;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign MonDReg       = mondreg_q;
   assign monitor_ready = ~jtag_pend & (state_q != ST_RD_JTAG);

endmodule

`default_nettype wire

// File: tb/tb_ocimem_access_arbiter.sv
// ============================================================================
//  Module   : tb_ocimem_access_arbiter
//  Purpose  : Directed scoreboard bench for ocimem_access_arbiter with a
//             behavioural 1-cycle-latency RAM attached to the ram_* port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ocimem_access_arbiter;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [37:0]       jdo;
   logic              take_a, take_b, debugack;
   logic [31:0]       MonDReg;
   logic              monitor_ready, monitor_error;
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read, avs_write;
   logic [31:0]       avs_writedata;
   logic [3:0]        avs_byteenable;
   logic [31:0]       avs_readdata;
   logic              avs_waitrequest;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [3:0]        ram_byteen;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   always #5 clk = ~clk;

   ocimem_access_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk                  (clk),
      .reset                (reset),
      .jdo                  (jdo),
      .take_action_ocimem_a (take_a),
      .take_action_ocimem_b (take_b),
      .debugack             (debugack),
      .MonDReg              (MonDReg),
      .monitor_ready        (monitor_ready),
      .monitor_error        (monitor_error),
      .avs_address          (avs_address),
      .avs_read             (avs_read),
      .avs_write            (avs_write),
      .avs_writedata        (avs_writedata),
      .avs_byteenable       (avs_byteenable),
      .avs_readdata         (avs_readdata),
      .avs_waitrequest      (avs_waitrequest),
      .ram_addr             (ram_addr),
      .ram_wren             (ram_wren),
      .ram_byteen           (ram_byteen),
      .ram_wdata            (ram_wdata),
      .ram_rdata            (ram_rdata)
   );

   // Behavioural single-port RAM, registered read
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (ram_wren)
         for (int b = 0; b < 4; b++)
            if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected", nm);
   endtask

   // Scoreboards: Avalon read data, JTAG op completions ({check MonDReg, data})
   logic [31:0] avs_q[$];
   logic [32:0] jtag_q[$];
   bit          log_q[$];   // 1 = Avalon read completion, 0 = JTAG write
   bit          log_en = 1'b0;
   int          wren_cnt = 0;
   logic        prev_ready = 1'b1;

   // Monitor: pops an expectation whenever the DUT completes a transfer
   always @(negedge clk) begin
      if (reset) begin
         prev_ready = 1'b1;
      end else begin
         if (ram_wren) wren_cnt++;
         if (log_en && ram_wren && !avs_write) log_q.push_back(1'b0);
         if (avs_read && !avs_write && !avs_waitrequest) begin
            if (log_en) log_q.push_back(1'b1);
            if (avs_q.size() == 0) fail_now("avs_unexpected_read");
            else check("avs_readdata", avs_readdata, avs_q.pop_front());
         end
         if (monitor_ready && !prev_ready) begin
            if (jtag_q.size() == 0) fail_now("jtag_unexpected_done");
            else begin
               logic [32:0] e;
               e = jtag_q.pop_front();
               if (e[32]) check("MonDReg", MonDReg, e[31:0]);
            end
         end
         prev_ready = monitor_ready;
      end
   end

   function automatic logic [37:0] jdo_a(input logic [7:0] a, input bit rd);
      logic [37:0] r;
      r = '0;
      r[34] = rd;
      r[17 +: 8] = a;
      return r;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] d);
      logic [37:0] r;
      r = '0;
      r[34:3] = d;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit is_b, input logic [37:0] d);
      jdo = d;
      if (is_b) take_b = 1'b1;
      else      take_a = 1'b1;
      tick();
      take_a = 1'b0;
      take_b = 1'b0;
   endtask

   task automatic wait_ready(output int low);
      low = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (monitor_ready) break;
         low++;
      end
      if (!monitor_ready) fail_now("monitor_ready_timeout");
      tick();
   endtask

   task automatic avs_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                           input int n, output int waits);
      int done;
      avs_address    = a;
      avs_writedata  = d;
      avs_byteenable = 4'hF;
      if (wr) avs_write = 1'b1;
      else    avs_read  = 1'b1;
      done  = 0;
      waits = 0;
      for (int i = 0; i < 200 && done < n; i++) begin
         @(negedge clk);
         if (!avs_waitrequest) done++;
         else waits++;
      end
      if (done < n) fail_now("avs_timeout");
      @(posedge clk);
      #1;
      avs_read  = 1'b0;
      avs_write = 1'b0;
   endtask

   initial begin
      int w, low, n0, cnt;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      reset = 1'b1; jdo = '0; take_a = 1'b0; take_b = 1'b0; debugack = 1'b1;
      avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = '0; avs_byteenable = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
      check("rst_ram_wren",    32'(ram_wren),        32'd0);
      check("rst_ready",       32'(monitor_ready),   32'd1);
      check("rst_error",       32'(monitor_error),   32'd0);
      check("rst_MonDReg",     MonDReg,              32'd0);
      reset = 1'b0;
      tick();

      // Avalon-only write then read
      avs_xfer(1'b1, 8'h10, 32'hDEADBEEF, 1, w);
      check("avs_wr_waits", 32'(w), 32'd0);
      avs_q.push_back(32'hDEADBEEF);
      avs_xfer(1'b0, 8'h10, 32'h0, 1, w);
      check("avs_rd_waits", 32'(w), 32'd1);

      // JTAG read of a preloaded word, then a write lands at the incremented address
      avs_xfer(1'b1, 8'h05, 32'h12345678, 1, w);
      jtag_q.push_back({1'b1, 32'h12345678});
      pulse(1'b0, jdo_a(8'h05, 1'b1));
      wait_ready(low);
      check("jrd_ready_low_cycles", 32'(low), 32'd2);
      jtag_q.push_back({1'b0, 32'h0});
      pulse(1'b1, jdo_b(32'hCAFE0006));
      wait_ready(low);
      check("jaddr_post_inc", mem[6], 32'hCAFE0006);

      // JTAG write at the top address, address wraps to zero
      pulse(1'b0, jdo_a(8'hFF, 1'b0));
      jtag_q.push_back({1'b0, 32'h0});
      pulse(1'b1, jdo_b(32'hA5A5A5A5));
      wait_ready(low);
      check("jwr_addr_ff", mem[255], 32'hA5A5A5A5);
      jtag_q.push_back({1'b0, 32'h0});
      pulse(1'b1, jdo_b(32'h0BADF00D));
      wait_ready(low);
      check("jaddr_wrap", mem[0], 32'h0BADF00D);

      // JTAG write refused outside debug mode
      pulse(1'b0, jdo_a(8'h80, 1'b0));
      debugack = 1'b0;
      n0 = wren_cnt;
      pulse(1'b1, jdo_b(32'h11111111));
      tick(); tick();
      check("nodbg_no_wren", 32'(wren_cnt - n0), 32'd0);
      check("nodbg_mem",     mem[128],           32'd0);
      check("nodbg_error",   32'(monitor_error), 32'd1);
      check("nodbg_ready",   32'(monitor_ready), 32'd1);
      debugack = 1'b1;

      // Overflow: second write strobe while the first is pending, Avalon busy
      pulse(1'b0, jdo_a(8'h60, 1'b0));
      check("a_clears_error", 32'(monitor_error), 32'd0);
      avs_q.push_back(32'hDEADBEEF);
      avs_q.push_back(32'hDEADBEEF);
      jtag_q.push_back({1'b0, 32'h0});
      fork
         begin
            int w2;
            avs_xfer(1'b0, 8'h10, 32'h0, 2, w2);
         end
         begin
            int l2;
            pulse(1'b1, jdo_b(32'hD1D1D1D1));
            pulse(1'b1, jdo_b(32'hD2D2D2D2));
            wait_ready(l2);
         end
      join
      check("ovf_error",     32'(monitor_error), 32'd1);
      check("ovf_first_wr",  mem[96],            32'hD1D1D1D1);
      check("ovf_second_wr", mem[97],            32'd0);
      pulse(1'b0, jdo_a(8'h70, 1'b0));
      check("ovf_error_clr", 32'(monitor_error), 32'd0);

      // Contention after reset: Avalon wins the first tie, then strict alternation
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      pulse(1'b0, jdo_a(8'h40, 1'b0));
      for (int i = 0; i < 4; i++) begin
         avs_q.push_back(32'hDEADBEEF);
         jtag_q.push_back({1'b0, 32'h0});
      end
      log_en = 1'b1;
      fork
         begin
            int w3;
            tick();
            avs_xfer(1'b0, 8'h10, 32'h0, 4, w3);
         end
         begin
            int l3;
            for (int j = 0; j < 4; j++) begin
               pulse(1'b1, jdo_b(32'h50000000 + 32'(j)));
               wait_ready(l3);
            end
         end
      join
      log_en = 1'b0;
      check("cont_ops", 32'(log_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < log_q.size(); i++)
         check($sformatf("cont_order_%0d", i), 32'(log_q[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_jwr_3", mem[67], 32'h50000003);

      // Reset during an Avalon read's data cycle
      jtag_q.push_back({1'b1, 32'hDEADBEEF});
      pulse(1'b0, jdo_a(8'h10, 1'b1));
      wait_ready(low);
      avs_address = 8'h10;
      avs_byteenable = 4'hF;
      avs_read = 1'b1;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("rstrd_waitrequest", 32'(avs_waitrequest), 32'd1);
      tick();
      @(negedge clk);
      check("rstrd_MonDReg", MonDReg,              32'd0);
      check("rstrd_ready",   32'(monitor_ready),   32'd1);
      check("rstrd_error",   32'(monitor_error),   32'd0);
      check("rstrd_wren",    32'(ram_wren),        32'd0);
      tick();
      avs_q.push_back(32'hDEADBEEF);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!avs_waitrequest) begin cnt = 1; break; end
      end
      check("rstrd_held_read_done", 32'(cnt), 32'd1);
      tick();
      avs_read = 1'b0;
      tick();

      check("sb_avs_empty",  32'(avs_q.size()),  32'd0);
      check("sb_jtag_empty", 32'(jtag_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
